switch_merge: RTL

//   Inverse of the 1-to-2 switch: merges two source channels (c1, c0) into one

---
 rtl/switch_merge.sv | 82 ++++++++
 1 files changed

// File: rtl/switch_merge.sv
// switch_merge: merges two source channels (c1, c0) into one sink channel (d)
// and tags each word with its source (d_s: 1 = c1, 0 = c0). Ties between the
// sources alternate round-robin; the output is a one-entry register.
//
// Handshake: on every side a word moves when valid and ready are both high
// in the same cycle. A source holds valid/data until it sees ready, and ready
// never depends on anything the source could change in response to ready.
//
// Optional build macro: SWITCH_MERGE_CNT_EN adds cnt1/cnt0, saturating
// counters of words delivered to the sink from each source.
module switch_merge #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c1_valid,
  input  logic [W-1:0]     c1_data,
  output logic             c1_ready,
  input  logic             c0_valid,
  input  logic [W-1:0]     c0_data,
  output logic             c0_ready,
  output logic             d_valid,
  output logic [W-1:0]     d_data,
  output logic             d_s,
  input  logic             d_ready
`ifdef SWITCH_MERGE_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt0
`endif
);

  logic last;     // source of the most recently accepted word
  logic load;     // output register can take a word this cycle
  logic grant;    // selected source when any is valid
  logic take;     // a source transfer happens this cycle

  // Arbitration and source readies; readies are forced low during reset.
  always_comb begin
    load = ~d_valid | d_ready;
    if (c1_valid && c0_valid) grant = ~last;
    else                      grant = c1_valid;
    c1_ready = rst_n & load &  grant & c1_valid;
    c0_ready = rst_n & load & ~grant & c0_valid;
    take     = c1_ready | c0_ready;
  end

  // Output register: refill on a source transfer, otherwise empty on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid <= 1'b0;
      d_data  <= '0;
      d_s     <= 1'b0;
      last    <= 1'b0;
    end else if (take) begin
      d_valid <= 1'b1;
      d_data  <= grant ? c1_data : c0_data;
      d_s     <= grant;
      last    <= grant;
    end else if (d_ready) begin
      d_valid <= 1'b0;
    end
  end

`ifdef SWITCH_MERGE_CNT_EN
  // Per-source delivered-word counters, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0;
      cnt0 <= '0;
    end else if (d_valid && d_ready) begin
      if (d_s) begin
        if (cnt1 != {CNT_W{1'b1}}) cnt1 <= cnt1 + 1'b1;
      end else begin
        if (cnt0 != {CNT_W{1'b1}}) cnt0 <= cnt0 + 1'b1;
      end
    end
  end
`endif

endmodule
